// File: rtl/priority_index_decoder.sv
// rtl/priority_index_decoder.sv - expands 8-bit priority codes into one-hot vectors through a small FIFO
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_code is the encoded index
//   out_valid/out_ready   consumer handshake; out_onehot/out_none describe the head entry
//   err_sticky, err_count invalid-code flag and saturating count
//   err_clr               clears both error outputs
module priority_index_decoder #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] NONE_CODE = 8'hF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_onehot,
    output logic        out_none,
    output logic        err_sticky,
    output logic [7:0]  err_count,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Each entry holds the already-decoded {none, onehot}.
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        code_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        bad_accept;
    logic [16:0] decoded;

    always_comb begin
        code_ok = (in_code < 8'd16) || (in_code == NONE_CODE);
        decoded = 17'd0;
        if (in_code == NONE_CODE) begin
            decoded = {1'b1, 16'h0000};
        end else begin
            decoded = {1'b0, 16'h0001 << in_code[3:0]};
        end
    end

    // Both handshakes depend only on registered occupancy, so nothing
    // on the output side is combinational from the input side.
    assign in_ready   = (count < FULL);
    assign out_valid  = (count != '0);
    assign accept     = in_valid && in_ready;
    assign push       = accept && code_ok;
    assign bad_accept = accept && !code_ok;
    assign pop        = out_valid && out_ready;

    assign out_onehot = out_valid ? mem[rd_ptr][15:0] : 16'h0000;
    assign out_none   = out_valid ? mem[rd_ptr][16]   : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A clear coinciding with a bad code restarts the tally at one
    // rather than losing the new error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else if (err_clr) begin
            err_sticky <= bad_accept;
            err_count  <= bad_accept ? 8'd1 : 8'd0;
        end else if (bad_accept) begin
            err_sticky <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
